// File: rtl/inst_encoder_pkg.sv
// Shared INST_* codes, MIPS opcode/funct constants and field packing helpers
// for the instruction encoder.
package inst_encoder_pkg;

    localparam logic [5:0] INST_NOP   = 6'd0;
    localparam logic [5:0] INST_ADDU  = 6'd1;
    localparam logic [5:0] INST_SUBU  = 6'd2;
    localparam logic [5:0] INST_SLT   = 6'd3;
    localparam logic [5:0] INST_JR    = 6'd4;
    localparam logic [5:0] INST_ORI   = 6'd5;
    localparam logic [5:0] INST_LW    = 6'd6;
    localparam logic [5:0] INST_SW    = 6'd7;
    localparam logic [5:0] INST_BEQ   = 6'd8;
    localparam logic [5:0] INST_LUI   = 6'd9;
    localparam logic [5:0] INST_ADDI  = 6'd10;
    localparam logic [5:0] INST_ADDIU = 6'd11;
    localparam logic [5:0] INST_J     = 6'd12;
    localparam logic [5:0] INST_JAL   = 6'd13;
    localparam logic [5:0] INST_HLT   = 6'd14;

    localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
    localparam logic [5:0] OPCODE_ORI     = 6'h0D;
    localparam logic [5:0] OPCODE_LW      = 6'h23;
    localparam logic [5:0] OPCODE_SW      = 6'h2B;
    localparam logic [5:0] OPCODE_BEQ     = 6'h04;
    localparam logic [5:0] OPCODE_LUI     = 6'h0F;
    localparam logic [5:0] OPCODE_ADDI    = 6'h08;
    localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
    localparam logic [5:0] OPCODE_J       = 6'h02;
    localparam logic [5:0] OPCODE_JAL     = 6'h03;
    localparam logic [5:0] OPCODE_HLT     = 6'h3F;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam int TARGET_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    // shamt is always packed as zero: none of the supported R-type ops use it
    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPCODE_SPECIAL, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational tuple -> {32-bit MIPS word, legal} packer.
// ENC_FIELD_CHECK_EN: reject tuples with nonzero reserved fields instead of zeroing them.
module inst_field_pack
    import inst_encoder_pkg::*;
(
    input  logic [5:0]          i_inst,
    input  logic [4:0]          i_rs,
    input  logic [4:0]          i_rt,
    input  logic [4:0]          i_rd,
    input  logic [4:0]          i_shamt,
    input  logic [15:0]         i_imm,
    input  logic [TARGET_W-1:0] i_target,
    output logic [31:0]         o_word,
    output logic                o_legal
);

`ifdef ENC_FIELD_CHECK_EN
    localparam bit FIELD_CHECK = 1'b1;
`else
    localparam bit FIELD_CHECK = 1'b0;
`endif

    logic w_known;
    logic w_rsv_bad;

    always_comb begin
        o_word    = '0;
        w_known   = 1'b1;
        w_rsv_bad = 1'b0;
        case (i_inst)
            INST_NOP:   o_word = '0;
            INST_ADDU: begin
                o_word    = pack_r(i_rs, i_rt, i_rd, FUNCT_ADDU);
                w_rsv_bad = (i_shamt != 5'd0);
            end
            INST_SUBU: begin
                o_word    = pack_r(i_rs, i_rt, i_rd, FUNCT_SUBU);
                w_rsv_bad = (i_shamt != 5'd0);
            end
            INST_SLT: begin
                o_word    = pack_r(i_rs, i_rt, i_rd, FUNCT_SLT);
                w_rsv_bad = (i_shamt != 5'd0);
            end
            INST_JR: begin
                o_word    = pack_r(i_rs, 5'd0, 5'd0, FUNCT_JR);
                w_rsv_bad = (i_rt != 5'd0) || (i_rd != 5'd0);
            end
            INST_ORI:   o_word = pack_i(OPCODE_ORI,   i_rs, i_rt, i_imm);
            INST_LW:    o_word = pack_i(OPCODE_LW,    i_rs, i_rt, i_imm);
            INST_SW:    o_word = pack_i(OPCODE_SW,    i_rs, i_rt, i_imm);
            INST_BEQ:   o_word = pack_i(OPCODE_BEQ,   i_rs, i_rt, i_imm);
            INST_ADDI:  o_word = pack_i(OPCODE_ADDI,  i_rs, i_rt, i_imm);
            INST_ADDIU: o_word = pack_i(OPCODE_ADDIU, i_rs, i_rt, i_imm);
            INST_LUI: begin
                o_word    = pack_i(OPCODE_LUI, 5'd0, i_rt, i_imm);
                w_rsv_bad = (i_rs != 5'd0);
            end
            INST_J:     o_word = {OPCODE_J,   i_target};
            INST_JAL:   o_word = {OPCODE_JAL, i_target};
            INST_HLT:   o_word = {OPCODE_HLT, 26'd0};
            default:    w_known = 1'b0;
        endcase
    end

    assign o_legal = w_known && !(FIELD_CHECK && w_rsv_bad);

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded instruction tuples into MIPS words and loads them into instruction memory.
// Build option ENC_FIELD_CHECK_EN (see inst_field_pack) turns reserved-field violations into errors.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | accepting tuples, one memory write per accepted legal tuple
// DONE    | HLT written or memory full; only start is honoured
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_inst,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_shamt,
    input  logic [15:0]         in_imm,
    input  logic [TARGET_W-1:0] in_target,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    enc_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_we;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_count;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_fire;
    logic              w_is_hlt;
    logic              w_last;

    inst_field_pack u_pack (
        .i_inst   (in_inst),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_rd     (in_rd),
        .i_shamt  (in_shamt),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_fire   = in_valid && r_ready;
    assign w_is_hlt = (in_inst == INST_HLT);
    assign w_last   = (r_wr_ptr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= BASE;
            r_mem_addr  <= BASE;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_wr_ptr   <= BASE;
                        r_mem_addr <= BASE;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_ready    <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_fire) begin
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_wr_ptr;
                            r_mem_wdata <= w_word;
                            r_count     <= r_count + CNT_ONE;
                            // pointer parks on the last address instead of wrapping
                            if (w_is_hlt || w_last) begin
                                r_state <= ST_DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
                                if (!w_is_hlt)
                                    r_err <= 1'b1;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + ADDR_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // a write registered just before reset must not reach memory during the reset cycle
    assign mem_we    = r_mem_we && rst_n;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign in_ready  = r_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder: reference word model, scoreboard of
// expected writes, and a word decoder for the round trip back to INST_* codes.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

`ifdef ENC_FIELD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int unsigned P26 = 32'h0400_0000;
    localparam int unsigned P21 = 32'h0020_0000;
    localparam int unsigned P16 = 32'h0001_0000;
    localparam int unsigned P11 = 32'h0000_0800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, s_start, in_valid;
    logic [5:0]  in_inst;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, mem_we, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;

    logic        s_in_ready, s_mem_we, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .err(err), .count(count)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .done(s_done), .err(s_err), .count(s_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {legal, word} from the instruction-set rules
    function automatic logic [32:0] model(input logic [5:0] c, input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
            input logic [15:0] imm, input logic [25:0] tg);
        int unsigned w = 0;
        int op = -1;
        int fn = -1;
        bit ok = 1'b1;
        bit bad = 1'b0;
        case (c)
            INST_ADDU:  fn = 33;
            INST_SUBU:  fn = 35;
            INST_SLT:   fn = 42;
            INST_JR:    fn = 8;
            INST_ORI:   op = 13;
            INST_LW:    op = 35;
            INST_SW:    op = 43;
            INST_BEQ:   op = 4;
            INST_LUI:   op = 15;
            INST_ADDI:  op = 8;
            INST_ADDIU: op = 9;
            INST_J:     op = 2;
            INST_JAL:   op = 3;
            default: ;
        endcase
        if (c == INST_NOP) w = 0;
        else if (c == INST_HLT) w = 63 * P26;
        else if (fn >= 0) begin
            if (c == INST_JR) begin
                w = rs * P21 + int'(fn);
                bad = (rt != 0) || (rd != 0);
            end else begin
                w = rs * P21 + rt * P16 + rd * P11 + int'(fn);
                bad = (sh != 0);
            end
        end else if (c == INST_J || c == INST_JAL) w = int'(op) * P26 + tg;
        else if (op >= 0) begin
            w = int'(op) * P26 + (c == INST_LUI ? 0 : rs * P21) + rt * P16 + imm;
            if (c == INST_LUI) bad = (rs != 0);
        end else ok = 1'b0;
        if (CHK && bad) ok = 1'b0;
        return {ok, w};
    endfunction

    function automatic logic [5:0] decode(input logic [31:0] w);
        int unsigned op = w >> 26;
        int unsigned fn = w & 63;
        logic [5:0] r = 6'h3E;
        if (w == 0) return INST_NOP;
        case (op)
            0: case (fn)
                33: r = INST_ADDU;
                35: r = INST_SUBU;
                42: r = INST_SLT;
                8:  r = INST_JR;
                default: r = 6'h3E;
            endcase
            13: r = INST_ORI;
            35: r = INST_LW;
            43: r = INST_SW;
            4:  r = INST_BEQ;
            15: r = INST_LUI;
            8:  r = INST_ADDI;
            9:  r = INST_ADDIU;
            2:  r = INST_J;
            3:  r = INST_JAL;
            63: r = INST_HLT;
            default: r = 6'h3E;
        endcase
        return r;
    endfunction

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] word;
        logic [5:0]  code;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    bit         m_load, m_done, m_err;
    logic [9:0] m_addr;
    int         m_count;

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", mem_wdata, mon_e.word);
                check("roundtrip_code", 32'(decode(mem_wdata)), 32'(mon_e.code));
            end
        end
    end

    task automatic send(input logic [5:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tg);
        logic [32:0] m;
        in_inst = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (m_load) begin
            m = model(c, rs, rt, rd, sh, imm, tg);
            if (!m[32]) m_err = 1'b1;
            else begin
                exp_q.push_back('{m_addr, m[31:0], c});
                m_count++;
                if (c == INST_HLT || m_addr == 10'h3FF) begin
                    m_load = 1'b0;
                    m_done = 1'b1;
                    if (c != INST_HLT) m_err = 1'b1;
                end else m_addr++;
            end
        end
        check("in_ready", 32'(in_ready), 32'(m_load));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!m_load) begin
            m_load = 1'b1; m_done = 1'b0; m_err = 1'b0; m_addr = '0; m_count = 0;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_ready"}, 32'(in_ready), 32'(m_load));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        start = 0; s_start = 0; in_valid = 0; in_inst = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_shamt = 0; in_imm = 0; in_target = 0;
        m_load = 0; m_done = 0; m_err = 0; m_addr = 0; m_count = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_values("reset");
        check("s_reset_ready", 32'(s_in_ready), 32'd0);
        check("s_reset_addr", 32'(s_mem_addr), 32'd0);

        // memory-full boundary on the 4-word instance
        s_start = 1'b1; @(posedge clk); #1 s_start = 1'b0;
        check("s_ready_after_start", 32'(s_in_ready), 32'd1);
        in_inst = INST_ADDU; in_rs = 1; in_rt = 2; in_rd = 3; in_shamt = 0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("s_full_we", 32'(s_mem_we), 32'(i < 4));
            if (i < 4) begin
                check("s_full_addr", 32'(s_mem_addr), 32'(i));
                check("s_full_data", s_mem_wdata, 32'h0022_1821);
            end
        end
        in_valid = 1'b0;
        check("s_full_done", 32'(s_done), 32'd1);
        check("s_full_err", 32'(s_err), 32'd1);
        check("s_full_count", 32'(s_count), 32'd4);
        check("s_full_ready", 32'(s_in_ready), 32'd0);
        s_start = 1'b1; @(posedge clk); #1 s_start = 1'b0;
        check("s_restart_err", 32'(s_err), 32'd0);
        check("s_restart_count", 32'(s_count), 32'd0);
        check("s_restart_addr", 32'(s_mem_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_inst = (i == 3) ? INST_HLT : INST_ADDU;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("s_hlt_last_done", 32'(s_done), 32'd1);
        check("s_hlt_last_err", 32'(s_err), 32'd0);
        check("s_hlt_last_count", 32'(s_count), 32'd4);
        check("s_hlt_last_data", s_mem_wdata, 32'hFC00_0000);

        // single R-type write and its one-cycle latency
        do_start();
        check_status("start");
        send(INST_ADDU, 1, 2, 3, 0, 0, 0);
        check("addu_we", 32'(mem_we), 32'd1);
        check("addu_addr", 32'(mem_addr), 32'd0);
        check("addu_data", mem_wdata, 32'h0022_1821);
        send(INST_HLT, 0, 0, 0, 0, 0, 0);
        do_start();

        // back-to-back program
        send(INST_ORI, 0, 1, 0, 0, 16'h1234, 0);
        send(INST_LUI, 0, 5, 0, 0, 16'hABCD, 0);
        send(INST_J, 0, 0, 0, 0, 0, 26'h100);
        send(INST_HLT, 0, 0, 0, 0, 0, 0);
        check("bb_hlt_word", mem_wdata, 32'hFC00_0000);
        check("bb_hlt_addr", 32'(mem_addr), 32'd3);
        check("bb_count", 32'(count), 32'd4);
        check("bb_done", 32'(done), 32'd1);
        check_status("bb");
        send(INST_ADDU, 4, 4, 4, 0, 0, 0);
        check_status("done_ignores");

        // reserved field, unknown code, start ignored in LOAD
        do_start();
        send(INST_LUI, 7, 5, 0, 0, 16'hABCD, 0);
`ifdef ENC_FIELD_CHECK_EN
        check("lui_rs_err", 32'(err), 32'd1);
        check("lui_rs_we", 32'(mem_we), 32'd0);
`else
        check("lui_rs_word", mem_wdata, 32'h3C05_ABCD);
        check("lui_rs_err", 32'(err), 32'd0);
`endif
        send(6'h3F, 1, 1, 1, 1, 16'h1, 26'h1);
        check("unknown_err", 32'(err), 32'd1);
        do_start();
        check_status("start_in_load");

        // random round trip over every legal non-HLT code
        for (int i = 0; i < 150; i++) begin
            logic [5:0] c;
            logic [4:0] sh, rd;
            c  = 6'($urandom_range(0, 13));
            sh = ($urandom % 2 == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom % 2 == 0) ? 5'd0 : 5'($urandom);
            send(c, 5'($urandom % 4 == 0 ? 0 : $urandom), 5'($urandom), rd, sh,
                 16'($urandom), 26'($urandom));
        end
        send(INST_HLT, 0, 0, 0, 0, 0, 0);
        check_status("random");

        // start while the final word is on the write port
        do_start();
        check_status("restart_on_last");
        check("restart_addr", 32'(mem_addr), 32'd0);

        // reset right after a handshake
        send(6'h3F, 0, 0, 0, 0, 0, 0);
        send(INST_ADDU, 9, 8, 7, 0, 0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        m_load = 0; m_done = 0; m_err = 0; m_addr = 0; m_count = 0;
        #1;
        check("we_in_reset", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        check_reset_values("midload_reset");
        rst_n = 1'b1;
        do_start();
        check_status("after_reset_start");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
